// File: rtl/ok_trigger_out_sched_if.sv
// ok_trigger_out_sched_if: user-side bundle of the Trigger Out scheduler.
// The master modport is the user/requester side. The slave modport is the
// scheduler side.
// Optional overflow signals exist only when OK_TRIGSCHED_OVERFLOW_EN is defined.
interface ok_trigger_out_sched_if #(
  parameter int NREQ = 16
);
  logic [NREQ-1:0] req;
  logic            enable;
  logic [15:0]     ep_trigger;
  logic [NREQ-1:0] pending;
  logic            busy;
`ifdef OK_TRIGSCHED_OVERFLOW_EN
  logic [NREQ-1:0] overflow;
  logic            clr_overflow;
`endif

`ifdef OK_TRIGSCHED_OVERFLOW_EN
  modport master (output req, enable, clr_overflow,
                  input  ep_trigger, pending, busy, overflow);
  modport slave  (input  req, enable, clr_overflow,
                  output ep_trigger, pending, busy, overflow);
`else
  modport master (output req, enable,
                  input  ep_trigger, pending, busy);
  modport slave  (input  req, enable,
                  output ep_trigger, pending, busy);
`endif
endinterface

// File: rtl/ok_trigger_out_sched.sv
// ok_trigger_out_sched: shares the 16-bit ep_trigger bus among NREQ requesters.
// Each requester's events are counted. They are then replayed as one-cycle
// pulses with a per-bit holdoff, so the endpoint's edge detector never merges
// two events.
// Optional macro OK_TRIGSCHED_OVERFLOW_EN adds sticky per-requester
// overflow flags and a clr_overflow input.

// Per-requester lane: pending counter, holdoff countdown, pulse register.
module ok_trigger_out_sched_lane #(
  parameter int CNT_W   = 4,
  parameter int HOLDOFF = 2
) (
  input  logic ep_clk,
  input  logic ep_reset,
  input  logic req,
  input  logic grant,
`ifdef OK_TRIGSCHED_OVERFLOW_EN
  input  logic clr_overflow,
  output logic overflow,
`endif
  output logic trig,
  output logic ready,
  output logic cnt_nz
);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [4:0]       HOLD_LOAD = 5'(HOLDOFF + 1);

  logic [CNT_W-1:0] cnt;
  logic [4:0]       hold;
  logic             sat;

  assign sat    = (cnt == CNT_MAX);
  assign cnt_nz = (cnt != '0);
  // A bit whose pulse is on the bus this cycle cannot be granted again.
  // This forces a low cycle before the holdoff countdown takes over.
  assign ready  = cnt_nz && (hold == 5'd0) && !trig;

  // Counter, holdoff and pulse register. A req and a grant in the same
  // cycle cancel out. A req arriving at saturation is dropped.
  always_ff @(posedge ep_clk) begin
    if (ep_reset) begin
      cnt  <= '0;
      hold <= '0;
      trig <= 1'b0;
    end else begin
      trig <= grant;
      if (grant && !req)
        cnt <= cnt - 1'b1;
      else if (req && !grant && !sat)
        cnt <= cnt + 1'b1;
      if (grant)
        hold <= HOLD_LOAD;
      else if (hold != 5'd0)
        hold <= hold - 5'd1;
    end
  end

`ifdef OK_TRIGSCHED_OVERFLOW_EN
  // Sticky loss flag. When a set and a clear land in the same cycle,
  // the set takes priority.
  always_ff @(posedge ep_clk) begin
    if (ep_reset)
      overflow <= 1'b0;
    else if (req && sat && !grant)
      overflow <= 1'b1;
    else if (clr_overflow)
      overflow <= 1'b0;
  end
`endif
endmodule

module ok_trigger_out_sched #(
  parameter int NREQ    = 16,
  parameter int CNT_W   = 4,
  parameter int HOLDOFF = 2
) (
  input  logic                 ep_clk,
  input  logic                 ep_reset,
  ok_trigger_out_sched_if.slave bus
);
  logic [NREQ-1:0] trig;
  logic [NREQ-1:0] ready;
  logic [NREQ-1:0] cnt_nz;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic [3:0]      ptr;
  logic [3:0]      gidx;
  logic [4:0]      idx;
  logic            found;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    ok_trigger_out_sched_lane #(
      .CNT_W   (CNT_W),
      .HOLDOFF (HOLDOFF)
    ) u_lane (
      .ep_clk       (ep_clk),
      .ep_reset     (ep_reset),
      .req          (bus.req[i]),
      .grant        (grant[i]),
`ifdef OK_TRIGSCHED_OVERFLOW_EN
      .clr_overflow (bus.clr_overflow),
      .overflow     (bus.overflow[i]),
`endif
      .trig         (trig[i]),
      .ready        (ready[i]),
      .cnt_nz       (cnt_nz[i])
    );
  end

  assign elig = ready & {NREQ{bus.enable}};

  // Round-robin pick: the first eligible index scanning from ptr,
  // wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + 5'(k);
      if (idx >= 5'(NREQ)) idx = idx - 5'(NREQ);
      if (!found && elig[idx[3:0]]) begin
        found = 1'b1;
        gidx  = idx[3:0];
      end
    end
  end

  // Decode the winning index to a one-hot grant vector.
  always_comb begin
    grant = '0;
    for (int k = 0; k < NREQ; k++)
      grant[k] = found && (gidx == 4'(k));
  end

  // The pointer moves just past the winner. With no grant it holds.
  always_ff @(posedge ep_clk) begin
    if (ep_reset)
      ptr <= '0;
    else if (found)
      ptr <= (gidx == 4'(NREQ - 1)) ? 4'd0 : gidx + 4'd1;
  end

  assign bus.ep_trigger = 16'(trig);
  assign bus.pending    = cnt_nz;
  assign bus.busy       = (|cnt_nz) || (|trig);
endmodule

// File: tb/tb_ok_trigger_out_sched.sv
// Directed bench for ok_trigger_out_sched.
// Instance A uses CNT_W=4 and instance B uses CNT_W=2; both use HOLDOFF=2.
module tb_ok_trigger_out_sched;
  logic ep_clk = 1'b0;
  logic ep_reset;
  always #5 ep_clk = ~ep_clk;

  ok_trigger_out_sched_if #(.NREQ(16)) bus_a();
  ok_trigger_out_sched_if #(.NREQ(16)) bus_b();

  ok_trigger_out_sched #(.NREQ(16), .CNT_W(4), .HOLDOFF(2)) dut_a (
    .ep_clk (ep_clk), .ep_reset (ep_reset), .bus (bus_a));
  ok_trigger_out_sched #(.NREQ(16), .CNT_W(2), .HOLDOFF(2)) dut_b (
    .ep_clk (ep_clk), .ep_reset (ep_reset), .bus (bus_b));

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ep_clk);
    #1;
  endtask

  initial begin
    logic [12:0] m13;
    logic [19:0] m20;
    logic [15:0] m16;
    logic [15:0] acc;

    ep_reset = 1'b1;
    bus_a.req = '0; bus_a.enable = 1'b0;
    bus_b.req = '0; bus_b.enable = 1'b0;
`ifdef OK_TRIGSCHED_OVERFLOW_EN
    bus_a.clr_overflow = 1'b0;
    bus_b.clr_overflow = 1'b0;
`endif
    step(); step();
    ep_reset = 1'b0;
    chk("rst_trig",    32'(bus_a.ep_trigger), 32'h0);
    chk("rst_pending", 32'(bus_a.pending),    32'h0);
    chk("rst_busy",    32'(bus_a.busy),       32'h0);
`ifdef OK_TRIGSCHED_OVERFLOW_EN
    chk("rst_ovf",     32'(bus_b.overflow),   32'h0);
`endif

    // Single event on bit 3.
    bus_a.enable = 1'b1;
    bus_a.req = 16'h0008;
    step();
    bus_a.req = '0;
    chk("single_pend", 32'(bus_a.pending),    32'h0008);
    chk("single_busy", 32'(bus_a.busy),       32'h1);
    chk("single_t0",   32'(bus_a.ep_trigger), 32'h0);
    step();
    chk("single_t1",   32'(bus_a.ep_trigger), 32'h0008);
    chk("single_pend2",32'(bus_a.pending),    32'h0);
    chk("single_busy2",32'(bus_a.busy),       32'h1);
    step();
    chk("single_t2",   32'(bus_a.ep_trigger), 32'h0);
    chk("single_idle", 32'(bus_a.busy),       32'h0);

    // Burst: req[0] held for 3 cycles gives pulses at cycles 1, 5 and 9.
    bus_a.req = 16'h0001;
    for (int c = 0; c < 13; c++) begin
      step();
      if (c == 2) bus_a.req = '0;
      m13[c] = bus_a.ep_trigger[0];
    end
    chk("burst_mask", 32'(m13), 32'h0222);
    chk("burst_idle", 32'(bus_a.busy), 32'h0);

    // Round-robin: bits 1, 2 and 5 together, with ptr=1 after the burst.
    bus_a.req = 16'h0026;
    step();
    bus_a.req = '0;
    step(); chk("rr_a1", 32'(bus_a.ep_trigger), 32'h0002);
    step(); chk("rr_a2", 32'(bus_a.ep_trigger), 32'h0004);
    step(); chk("rr_a3", 32'(bus_a.ep_trigger), 32'h0020);
    for (int c = 0; c < 6; c++) step();
    // ptr=6: the scan wraps, so bit 1 is served before bit 2.
    bus_a.req = 16'h0006;
    step();
    bus_a.req = '0;
    step(); chk("rr_b1", 32'(bus_a.ep_trigger), 32'h0002);
    step(); chk("rr_b2", 32'(bus_a.ep_trigger), 32'h0004);
    for (int c = 0; c < 6; c++) step();

    // Enable gating: four events are held, then replayed once enabled.
    bus_a.enable = 1'b0;
    bus_a.req = 16'h0080;
    acc = '0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 3) bus_a.req = '0;
      acc = acc | bus_a.ep_trigger;
    end
    chk("gate_quiet", 32'(acc), 32'h0);
    chk("gate_pend",  32'(bus_a.pending), 32'h0080);
    bus_a.enable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      m20[c] = bus_a.ep_trigger[7];
    end
    chk("gate_mask", 32'(m20), 32'h01111);
    chk("gate_idle", 32'(bus_a.busy), 32'h0);

    // Saturation on instance B: the counter caps at 3, so 5 events give 3 pulses.
    bus_b.req = 16'h0010;
    for (int c = 0; c < 5; c++) step();
    bus_b.req = '0;
    chk("sat_pend", 32'(bus_b.pending), 32'h0010);
`ifdef OK_TRIGSCHED_OVERFLOW_EN
    chk("sat_ovf",  32'(bus_b.overflow), 32'h0010);
    step();
    chk("sat_ovf_sticky", 32'(bus_b.overflow), 32'h0010);
    bus_b.clr_overflow = 1'b1;
    step();
    bus_b.clr_overflow = 1'b0;
    chk("sat_ovf_clr", 32'(bus_b.overflow), 32'h0);
`endif
    bus_b.enable = 1'b1;
    for (int c = 0; c < 16; c++) begin
      step();
      m16[c] = bus_b.ep_trigger[4];
    end
    chk("sat_mask", 32'(m16), 32'h0111);
    chk("sat_idle", 32'(bus_b.busy), 32'h0);

    // Reset mid-burst: cnt[2] reaches 3 and the first pulse is on the bus.
    bus_a.enable = 1'b0;
    bus_a.req = 16'h0004;
    step(); step(); step();
    bus_a.req = '0;
    chk("mid_pend", 32'(bus_a.pending), 32'h0004);
    bus_a.enable = 1'b1;
    step();
    chk("mid_trig", 32'(bus_a.ep_trigger), 32'h0004);
    ep_reset = 1'b1;
    step();
    chk("mid_rst_trig", 32'(bus_a.ep_trigger), 32'h0);
    chk("mid_rst_pend", 32'(bus_a.pending),    32'h0);
    chk("mid_rst_busy", 32'(bus_a.busy),       32'h0);
    ep_reset = 1'b0;
    acc = '0;
    for (int c = 0; c < 10; c++) begin
      step();
      acc = acc | bus_a.ep_trigger;
    end
    chk("mid_after", 32'(acc), 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
